// File: rtl/lp_rx_if.sv
// LP receive lane signals: comparator inputs and enable from the PHY side,
// decoded line state and HS-RX control back out.
interface lp_rx_if;
  logic       LPRX_EN;
  logic       Dp;
  logic       Dn;
  logic [1:0] line_state;
  logic       Stopstate;
  logic       HSTERM_EN;
  logic       HSRX_EN;
  logic       RxEscEntry;
  logic       ErrControl;

  modport slave (
    input  LPRX_EN,
    input  Dp,
    input  Dn,
    output line_state,
    output Stopstate,
    output HSTERM_EN,
    output HSRX_EN,
    output RxEscEntry,
    output ErrControl
  );

  modport master (
    output LPRX_EN,
    output Dp,
    output Dn,
    input  line_state,
    input  Stopstate,
    input  HSTERM_EN,
    input  HSRX_EN,
    input  RxEscEntry,
    input  ErrControl
  );
endinterface

// File: rtl/lp_rx.sv
// D-PHY data-lane LP receive controller: synchronises and filters Dp/Dn, decodes the LP
// line-state sequences and drives HS termination / receiver enables.
module lp_rx #(
  parameter int unsigned FILTER_LEN = 2,
  parameter int unsigned LPX_MIN    = 8,
  parameter int unsigned HSSETTLE   = 6
) (
  input  logic   LPRX_CLK,
  input  logic   RxRSt,
  lp_rx_if.slave lane
);

  localparam int unsigned HistW    = 2 * FILTER_LEN;
  localparam logic [4:0]  LpxMin   = 5'(LPX_MIN);
  localparam logic [4:0]  HsSettle = 5'(HSSETTLE);
  localparam logic [4:0]  TimerMax = 5'd31;

  localparam logic [1:0] Lp00 = 2'b00;
  localparam logic [1:0] Lp01 = 2'b01;
  localparam logic [1:0] Lp10 = 2'b10;
  localparam logic [1:0] Lp11 = 2'b11;

  typedef enum logic [3:0] {
    StStop,
    StHsRqst,
    StHsPrpr,
    StHsActive,
    StEscRqst,
    StEscBrdg,
    StEscAck,
    StEscMode,
    StErrWait
  } state_e;

  logic [1:0]       sync1_q, sync2_q;
  logic [HistW-1:0] hist_q, hist_d;
  logic [1:0]       ls_q, ls_d;
  logic             hist_agree;
  state_e           state_q, state_d;
  logic [4:0]       timer_q, timer_d;
  logic             err_q, err_d;
  logic             esc_q, esc_d;
  logic             go_err;

  // Synchronisers run regardless of LPRX_EN.
  always_ff @(posedge LPRX_CLK or posedge RxRSt) begin
    if (RxRSt) begin
      sync1_q <= Lp11;
      sync2_q <= Lp11;
    end else begin
      sync1_q <= {lane.Dp, lane.Dn};
      sync2_q <= sync1_q;
    end
  end

  // History: newest sample in the low two bits, oldest shifted out of the top.
  always_comb begin
    hist_agree = (hist_q == {FILTER_LEN{hist_q[1:0]}});
    ls_d       = ls_q;
    if (!lane.LPRX_EN) begin
      hist_d = '1;
      ls_d   = Lp11;
    end else begin
      hist_d = HistW'({hist_q, sync2_q});
      if (hist_agree && (hist_q[1:0] != ls_q)) begin
        ls_d = hist_q[1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    esc_d   = 1'b0;
    go_err  = 1'b0;
    if (!lane.LPRX_EN) begin
      state_d = StStop;
    end else begin
      case (state_q)
        StStop: begin
          case (ls_q)
            Lp01:    state_d = StHsRqst;
            Lp10:    state_d = StEscRqst;
            Lp00:    go_err  = 1'b1;
            default: ;
          endcase
        end
        StHsRqst: begin
          case (ls_q)
            Lp00: begin
              if (timer_q >= LpxMin) state_d = StHsPrpr;
              else                   go_err  = 1'b1;
            end
            Lp11:    state_d = StStop;
            Lp10:    go_err  = 1'b1;
            default: ;
          endcase
        end
        StHsPrpr: begin
          case (ls_q)
            Lp00:    if (timer_q >= HsSettle) state_d = StHsActive;
            Lp11:    state_d = StStop;
            default: go_err  = 1'b1;
          endcase
        end
        // HS swing reads as LP-00 and the trail may glitch; only LP-11 ends these.
        StHsActive, StEscMode, StErrWait: begin
          if (ls_q == Lp11) state_d = StStop;
        end
        StEscRqst: begin
          case (ls_q)
            Lp00:    state_d = StEscBrdg;
            Lp11:    state_d = StStop;
            Lp01:    go_err  = 1'b1;
            default: ;
          endcase
        end
        StEscBrdg: begin
          case (ls_q)
            Lp01:    state_d = StEscAck;
            Lp11:    state_d = StStop;
            Lp10:    go_err  = 1'b1;
            default: ;
          endcase
        end
        StEscAck: begin
          case (ls_q)
            Lp00: begin
              state_d = StEscMode;
              esc_d   = 1'b1;
            end
            Lp11:    state_d = StStop;
            Lp10:    go_err  = 1'b1;
            default: ;
          endcase
        end
        default: state_d = StStop;
      endcase
      if (go_err) begin
        state_d = StErrWait;
        err_d   = 1'b1;
      end
    end

    if (!lane.LPRX_EN || (state_d != state_q)) begin
      timer_d = '0;
    end else if (timer_q == TimerMax) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 5'd1;
    end
  end

  always_ff @(posedge LPRX_CLK or posedge RxRSt) begin
    if (RxRSt) begin
      hist_q  <= '1;
      ls_q    <= Lp11;
      state_q <= StStop;
      timer_q <= '0;
      err_q   <= 1'b0;
      esc_q   <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      ls_q    <= ls_d;
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      esc_q   <= esc_d;
    end
  end

  // Enables decode straight from state so reset and LPRX_EN act without a clock edge.
  always_comb begin
    lane.line_state = ls_q;
    lane.Stopstate  = lane.LPRX_EN && (state_q == StStop);
    lane.HSTERM_EN  = lane.LPRX_EN && ((state_q == StHsPrpr) || (state_q == StHsActive));
    lane.HSRX_EN    = lane.LPRX_EN && (state_q == StHsActive);
    lane.RxEscEntry = esc_q;
    lane.ErrControl = err_q;
  end

endmodule

// File: tb/tb_lp_rx.sv
// Directed bench for lp_rx: a sequence-level lane model checked every cycle, plus
// hand-computed latency and pulse-count expectations for each scenario.
module tb_lp_rx;
  localparam int FL  = 2;
  localparam int LPX = 8;
  localparam int HSS = 6;

  localparam int MStop     = 0;
  localparam int MHsRqst   = 1;
  localparam int MHsPrpr   = 2;
  localparam int MHsActive = 3;
  localparam int MEscRqst  = 4;
  localparam int MEscBrdg  = 5;
  localparam int MEscAck   = 6;
  localparam int MEscMode  = 7;
  localparam int MErrWait  = 8;

  typedef struct {
    int         st;
    int         dwell;
    logic [1:0] ls;
    logic [1:0] run_val;
    int         run_len;
    logic [1:0] p1;
    logic [1:0] p2;
    bit         err;
    bit         esc;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  mdl_t m;

  int n_chk = 0;
  int n_bad = 0;

  int err_cnt = 0, esc_cnt = 0, term_cnt = 0, not11_cnt = 0, nostop_cnt = 0;
  int term_rise = 0, term_fall = 0, rx_rise = 0, stop_rise = 0, ls00_cyc = 0;
  int drive_cyc = 0;
  bit term_prev = 0, rx_prev = 0, stop_prev = 0;
  logic [1:0] ls_prev = 2'b11;

  lp_rx_if lane ();

  lp_rx #(
    .FILTER_LEN (FL),
    .LPX_MIN    (LPX),
    .HSSETTLE   (HSS)
  ) dut (
    .LPRX_CLK (clk),
    .RxRSt    (rst),
    .lane     (lane)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.st = MStop; r.dwell = 0; r.ls = 2'b11; r.run_val = 2'b11; r.run_len = FL;
    r.p1 = 2'b11; r.p2 = 2'b11; r.err = 0; r.esc = 0;
    return r;
  endfunction

  // Lane protocol rules: from stop, 01/10 open a request; elsewhere LP-11 always returns
  // to stop; each request state advances on one LS, tolerates the LS it entered on,
  // and treats anything else as an error.
  function automatic int next_state(int s, logic [1:0] l, int dw, output bit e);
    logic [1:0] held, adv;
    int nxt;
    e = 0;
    if (s == MStop) begin
      if (l == 2'b01) return MHsRqst;
      if (l == 2'b10) return MEscRqst;
      if (l == 2'b00) begin e = 1; return MErrWait; end
      return MStop;
    end
    if (l == 2'b11) return MStop;
    if (s == MHsActive || s == MEscMode || s == MErrWait) return s;
    held = 2'b00; adv = 2'b00; nxt = s;
    case (s)
      MHsRqst:  begin held = 2'b01; adv = 2'b00; nxt = MHsActive - 1; end
      MHsPrpr:  begin held = 2'b00; adv = 2'b00; nxt = MHsActive;     end
      MEscRqst: begin held = 2'b10; adv = 2'b00; nxt = MEscBrdg;      end
      MEscBrdg: begin held = 2'b00; adv = 2'b01; nxt = MEscAck;       end
      MEscAck:  begin held = 2'b01; adv = 2'b00; nxt = MEscMode;      end
      default:  ;
    endcase
    if (l == adv && s == MHsRqst) begin
      if (dw >= LPX) return nxt;
      e = 1;
      return MErrWait;
    end
    if (l == adv && s == MHsPrpr) return (dw >= HSS) ? nxt : s;
    if (l == adv) return nxt;
    if (l == held) return s;
    e = 1;
    return MErrWait;
  endfunction

  // One clock of the lane: pins delayed two samples, accepted once the last FL samples agree.
  function automatic mdl_t step(mdl_t c, logic [1:0] pins, logic en);
    mdl_t n;
    int ns;
    bit e;
    n = c;
    n.err = 0;
    n.esc = 0;
    n.p1 = pins;
    n.p2 = c.p1;
    if (!en) begin
      n.st = MStop; n.dwell = 0; n.ls = 2'b11; n.run_val = 2'b11; n.run_len = FL;
      return n;
    end
    if (c.run_len >= FL && c.run_val != c.ls) n.ls = c.run_val;
    if (c.p2 == c.run_val) n.run_len = (c.run_len < FL) ? c.run_len + 1 : FL;
    else begin
      n.run_val = c.p2;
      n.run_len = 1;
    end
    ns = next_state(c.st, c.ls, c.dwell, e);
    n.err = e;
    n.esc = (c.st == MEscAck) && (ns == MEscMode);
    n.dwell = (ns != c.st) ? 0 : ((c.dwell < 31) ? c.dwell + 1 : 31);
    n.st = ns;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= mdl_reset();
    else     m <= step(m, {lane.Dp, lane.Dn}, lane.LPRX_EN);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input logic [1:0] v, input int n);
    {lane.Dp, lane.Dn} = v;
    drive_cyc = cyc;
    tick(n);
  endtask

  int e0, x0, t0, a0, b0;

  initial begin
    lane.LPRX_EN = 1'b1;
    lane.Dp = 1'b1;
    lane.Dn = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          check("cyc_line_state", lane.line_state, m.ls);
          check("cyc_Stopstate", lane.Stopstate, lane.LPRX_EN && (m.st == MStop));
          check("cyc_HSTERM_EN", lane.HSTERM_EN,
                lane.LPRX_EN && (m.st == MHsPrpr || m.st == MHsActive));
          check("cyc_HSRX_EN", lane.HSRX_EN, lane.LPRX_EN && (m.st == MHsActive));
          check("cyc_RxEscEntry", lane.RxEscEntry, m.esc);
          check("cyc_ErrControl", lane.ErrControl, m.err);
        end
      end
      forever begin
        @(negedge clk);
        if (lane.ErrControl) err_cnt++;
        if (lane.RxEscEntry) esc_cnt++;
        if (lane.HSTERM_EN) term_cnt++;
        if (lane.line_state != 2'b11) not11_cnt++;
        if (!lane.Stopstate) nostop_cnt++;
        if (lane.HSTERM_EN && !term_prev) term_rise = cyc;
        if (!lane.HSTERM_EN && term_prev) term_fall = cyc;
        if (lane.HSRX_EN && !rx_prev) rx_rise = cyc;
        if (lane.Stopstate && !stop_prev) stop_rise = cyc;
        if (lane.line_state == 2'b00 && ls_prev != 2'b00) ls00_cyc = cyc;
        term_prev = lane.HSTERM_EN;
        rx_prev   = lane.HSRX_EN;
        stop_prev = lane.Stopstate;
        ls_prev   = lane.line_state;
      end
    join_none

    tick(3);
    check("rst_stopstate", lane.Stopstate, 1);
    check("rst_hsterm", lane.HSTERM_EN, 0);
    check("rst_line_state", lane.line_state, 2'b11);
    rst = 1'b0;
    tick(5);

    // HS burst
    e0 = err_cnt;
    drive(2'b11, 10);
    drive(2'b01, 12);
    drive(2'b00, 30);
    drive(2'b11, 10);
    check("hs_term_after_ls00", term_rise - ls00_cyc, 1);
    check("hs_settle", rx_rise - term_rise, 7);
    // capture edge is drive_cyc+1; outputs follow FILTER_LEN+3 edges later
    check("hs_exit_latency", stop_rise - drive_cyc, 6);
    check("hs_exit_term_with_stop", term_fall, stop_rise);
    check("hs_no_err", err_cnt - e0, 0);

    // Short request
    e0 = err_cnt; t0 = term_cnt;
    drive(2'b01, 5);
    drive(2'b00, 10);
    check("short_in_err_wait", lane.Stopstate, 0);
    drive(2'b11, 10);
    check("short_err_once", err_cnt - e0, 1);
    check("short_no_term", term_cnt - t0, 0);
    check("short_recover", lane.Stopstate, 1);

    // Escape entry
    e0 = err_cnt; x0 = esc_cnt; t0 = term_cnt;
    drive(2'b10, 6);
    drive(2'b00, 6);
    drive(2'b01, 6);
    drive(2'b00, 6);
    drive(2'b11, 10);
    check("esc_once", esc_cnt - x0, 1);
    check("esc_no_term", term_cnt - t0, 0);
    check("esc_no_err", err_cnt - e0, 0);
    check("esc_recover", lane.Stopstate, 1);

    // Glitch rejection
    a0 = not11_cnt; b0 = nostop_cnt;
    drive(2'b01, 1);
    drive(2'b11, 10);
    check("glitch_ls_stays", not11_cnt - a0, 0);
    check("glitch_stop_stays", nostop_cnt - b0, 0);
    check("glitch_line_state", lane.line_state, 2'b11);

    // Enable dropped mid-HS
    drive(2'b01, 12);
    drive(2'b00, 15);
    check("en_hsrx_on", lane.HSRX_EN, 1);
    lane.LPRX_EN = 1'b0;
    tick(1);
    check("en_off_term", lane.HSTERM_EN, 0);
    check("en_off_hsrx", lane.HSRX_EN, 0);
    {lane.Dp, lane.Dn} = 2'b11;
    tick(3);
    lane.LPRX_EN = 1'b1;
    tick(8);
    check("en_back_stop", lane.Stopstate, 1);

    // Reset mid-HS
    drive(2'b01, 12);
    drive(2'b00, 15);
    check("rst_hsrx_on", lane.HSRX_EN, 1);
    rst = 1'b1;
    #1;
    check("rst_async_term", lane.HSTERM_EN, 0);
    check("rst_async_hsrx", lane.HSRX_EN, 0);
    check("rst_async_stop", lane.Stopstate, 1);
    tick(2);
    {lane.Dp, lane.Dn} = 2'b11;
    tick(1);
    rst = 1'b0;
    e0 = err_cnt; x0 = esc_cnt;
    tick(8);
    check("rst_release_stop", lane.Stopstate, 1);
    check("rst_release_no_err", err_cnt - e0, 0);
    check("rst_release_no_esc", esc_cnt - x0, 0);

    // Illegal 11 -> 00
    e0 = err_cnt;
    drive(2'b00, 8);
    check("ill_err_once", err_cnt - e0, 1);
    check("ill_not_stop", lane.Stopstate, 0);
    drive(2'b11, 8);
    check("ill_recover", lane.Stopstate, 1);
    check("ill_err_still_once", err_cnt - e0, 1);

    tick(3);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/lp_rx.md
# lp_rx

D-PHY data-lane low-power receive controller, the receiving counterpart of the LP transmitter. It synchronises and glitch-filters the single-ended LP comparator outputs on Dp/Dn and decodes the LP line-state sequences for stop, HS entry, HS exit and escape entry. From that decoding it drives the HS termination and HS receiver enables for the lane's HS-RX path and flags illegal sequences to the upper layer.

## Interface
- FILTER_LEN, 2: consecutive synchronised samples (1..8) a new line state must hold before it is accepted.
- LPX_MIN, 8: minimum cycles (0..31) in LP-01 before LP-00 is accepted as HS-prepare.
- HSSETTLE, 6: cycles (0..31) in HS-prepare, with termination on, before the HS receiver is enabled.
- LPRX_CLK  in  1  LP receive clock; all logic on its rising edge.
- RxRSt  in  1  asynchronous, active-high reset.
- LPRX_EN  in  1  upper-layer enable; synchronous hold-in-idle when low.
- Dp, Dn  in  1 each  LP comparator outputs; asynchronous to LPRX_CLK.
- line_state  out  2  filtered {Dp,Dn}, registered.
- Stopstate  out  1  lane in RX_STOP.
- HSTERM_EN  out  1  enable HS differential termination.
- HSRX_EN  out  1  enable HS receiver / deserialiser.
- RxEscEntry  out  1  one-cycle pulse on escape-mode entry.
- ErrControl  out  1  one-cycle pulse on an illegal LP sequence.

## Operation
- Sync: each of Dp and Dn passes through a 2-flop synchroniser (s1, s2).
- Filter: a FILTER_LEN-deep history holds s2. On any edge where all history entries equal X and X differs from line_state, line_state takes X.
- Timer: 5 bits. Cleared on every state change, otherwise increments each cycle and saturates at 31.
- FSM transitions are evaluated on the registered line_state (LS). "err" below means: go to RX_ERR_WAIT and pulse ErrControl.
  - RX_STOP: LS=01 goes to RX_HS_RQST. LS=10 goes to RX_ESC_RQST. LS=00 is err.
  - RX_HS_RQST: LS=00 with timer>=LPX_MIN goes to RX_HS_PRPR. LS=00 with timer<LPX_MIN is err. LS=11 goes to RX_STOP with no error. LS=10 is err.
  - RX_HS_PRPR: LS=00 with timer>=HSSETTLE goes to RX_HS_ACTIVE. LS=11 goes to RX_STOP. LS=01 or 10 is err.
  - RX_HS_ACTIVE: LS=11 (HS exit) goes to RX_STOP. LS=00/01/10 are ignored, because HS swing reads as LP-00 and the trail may glitch.
  - RX_ESC_RQST: LS=00 goes to RX_ESC_BRDG. LS=11 goes to RX_STOP. LS=01 is err.
  - RX_ESC_BRDG: LS=01 goes to RX_ESC_ACK. LS=11 goes to RX_STOP. LS=10 is err.
  - RX_ESC_ACK: LS=00 goes to RX_ESC_MODE and pulses RxEscEntry. LS=11 goes to RX_STOP. LS=10 is err.
  - RX_ESC_MODE: LS=11 goes to RX_STOP. Escape commands are not decoded in this block.
  - RX_ERR_WAIT: LS=11 goes to RX_STOP.
- Outputs:
  - Stopstate = LPRX_EN and state is RX_STOP.
  - HSTERM_EN = LPRX_EN and state is RX_HS_PRPR or RX_HS_ACTIVE.
  - HSRX_EN = LPRX_EN and state is RX_HS_ACTIVE.
- LPRX_EN=0: on each edge, state goes to RX_STOP, timer to 0, the history fills with 11 and line_state to 11. No pulses are issued. Synchronisers keep running.

## Timing
- Reset (async assert, any time, including mid-HS):
  - state RX_STOP, timer 0, s1/s2/history/line_state all 11, pulses 0.
  - HSTERM_EN=0, HSRX_EN=0 immediately; Stopstate = LPRX_EN.
- Filter latency: a pin change first captured by s1 at edge k appears on line_state after edge k+FILTER_LEN+2 (4 cycles at default).
- A pulse shorter than FILTER_LEN cycles never reaches line_state.
- FSM latency: the state changes on the edge after line_state changes.
  - Stopstate, HSTERM_EN and HSRX_EN follow the state in the same cycle.
  - Pin-to-output latency is therefore FILTER_LEN+3 edges.
- ErrControl and RxEscEntry are registered alongside state: high for exactly the one cycle after the transition edge.
- HSRX_EN rises HSSETTLE+1 cycles after HSTERM_EN rises.
- HS exit: HSTERM_EN and HSRX_EN fall in the same cycle Stopstate rises.
- An LPX_MIN check at exactly timer==LPX_MIN passes.

## Test plan
- HS burst at defaults:
  - Stimulus: LP-11 for 10 cycles, LP-01 for 12, LP-00 for 30, then LP-11.
  - Required: Stopstate drops when line_state=01; HSTERM_EN rises when line_state=00; HSRX_EN rises 7 cycles later; both fall and Stopstate rises 5 edges after Dp/Dn return to 11; ErrControl never asserts.
- Short request:
  - Stimulus: LP-01 held 5 cycles (line_state 01 for ~5 cycles, below LPX_MIN=8), then LP-00.
  - Required: one ErrControl pulse, HSTERM_EN stays 0, lane in RX_ERR_WAIT until LP-11, then Stopstate=1.
- Escape entry:
  - Stimulus: 11, 10, 00, 01, 00, each held 6 cycles, then 11.
  - Required: exactly one RxEscEntry pulse, HSTERM_EN=0 throughout, Stopstate=1 after the return to 11.
- Glitch rejection: a 1-cycle LP-01 glitch during stop leaves line_state=11 and Stopstate=1 with no state change.
- Enable and reset:
  - LPRX_EN=0 mid-HS: HSTERM_EN=0 and HSRX_EN=0 on the next edge.
  - RxRSt=1 mid-HS: outputs clear immediately, without waiting for an edge.
  - After release: Stopstate=1 with no pulses.
- Illegal direct 11 to 00: one ErrControl pulse, then recovery to RX_STOP on LP-11.
